hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter MULT_CYCLES, default 5, busy duration of mult/multu in cycles.
REQ-002 Parameter DIV_CYCLES, default 10, busy duration of div/divu in cycles.
REQ-003 clk  in  1  clock; all state updates on posedge clk.
REQ-004 reset  in  1  reset, synchronous, active-high.
REQ-005 rs_D, rt_D  in  5 each  source register numbers of the instruction in D.
REQ-006 tuse_rs_D, tuse_rt_D  in  2 each  cycles until operand needed; 3 = operand unused.
REQ-007 md_D  in  1  instruction in D uses the mult/div unit (mult/div/mfhi/mflo/mthi/mtlo).
REQ-008 wa_E, wa_M  in  5 each  destination register of the instruction in E / M; 0 = no write.
REQ-009 tnew_E, tnew_M  in  2 each  cycles until result is forwardable from that stage.
REQ-010 md_start_E  in  1  mult/div instruction is in E this cycle (one-cycle pulse).
REQ-011 md_is_div_E  in  1  qualifies md_start_E: 1 = div/divu, 0 = mult/multu.
REQ-012 stall_F  out  1  hold PC.
REQ-013 stall_D  out  1  hold the F/D pipeline register.
REQ-014 flush_E  out  1  load a bubble (all-zero instruction) into the D/E pipeline register.
REQ-015 md_busy  out  1  mult/div unit is computing.
REQ-016 stall_cnt  out  32  saturating count of stalled cycles since reset.
REQ-017 proto_err  out  1  sticky flag, md_start_E seen while md_busy = 1.

Function
REQ-018 rs hazard SHALL be true iff rs_D != 0, tuse_rs_D != 3, and either (rs_D == wa_E and tnew_E > tuse_rs_D) or (rs_D == wa_M and tnew_M > tuse_rs_D).
REQ-019 rt hazard SHALL use the same rule with rt_D and tuse_rt_D.
REQ-020 md hazard SHALL be true iff md_D = 1 and (md_start_E = 1 or md_busy = 1).
REQ-021 stall SHALL be the OR of rs, rt and md hazards; stall_F = stall_D = flush_E = stall, combinational, same-cycle (zero latency).
REQ-022 Busy counter: 4-bit down-counter; md_busy = (count != 0).
REQ-023 When md_start_E = 1 and count = 0, count SHALL load DIV_CYCLES if md_is_div_E else MULT_CYCLES on the next edge.
REQ-024 When count != 0, count SHALL decrement by 1 each cycle; md_busy falls on the edge where count reaches 0.
REQ-025 md_start_E while count != 0 SHALL NOT reload or alter count; proto_err SHALL set on the next edge and hold until reset.
REQ-026 stall_cnt SHALL increment on each edge where stall = 1 and saturate at 32'hFFFFFFFF.
REQ-027 Comparisons against wa_E/wa_M with value 0 SHALL never produce a hazard (register $0).
REQ-028 MULT_CYCLES and DIV_CYCLES SHALL be in range 1..15.

Reset
REQ-029 On reset: count = 0, md_busy = 0, stall_cnt = 0, proto_err = 0.
REQ-030 Reset mid-operation SHALL abort the busy count immediately; stall outputs during reset are combinational from inputs with md_busy treated as 0.

Structure
REQ-031 Shared package pipe_pkg SHALL hold TUSE_NONE (3), REG_ZERO (0), MULT_CYCLES and DIV_CYCLES defaults and the 2-bit tuse/tnew width.
REQ-032 The busy counter (REQ-022..025, proto_err) SHALL be a sub-module md_busy_counter; hazard compare logic and stall_cnt stay in hazard_ctrl.

Verification
REQ-033 Load-use: wa_E=8, tnew_E=2, rs_D=8, tuse_rs_D=1 -> stall=1 for that cycle; next cycle wa_M=8, tnew_M=1 -> stall=0.
REQ-034 $0 guard: rs_D=0, wa_E=0, tnew_E=2, tuse_rs_D=0 -> stall=0, stall_cnt unchanged.
REQ-035 Mult busy: md_start_E=1, md_is_div_E=0, then md_D=1 held -> stall=1 for 6 cycles (start cycle + 5 busy), md_busy high exactly 5 cycles.
REQ-036 Div busy with reset: md_start_E=1, md_is_div_E=1, reset asserted after 4 cycles -> md_busy=0, stall=0 next cycle, stall_cnt=0.
REQ-037 Protocol error: md_start_E pulsed at count=3 -> count continues 2,1,0 unchanged, proto_err=1 and stays 1 until reset.
REQ-038 Saturation: force 2^32+5 stalled cycles (or preload via bench hook) -> stall_cnt holds 32'hFFFFFFFF.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg -- shared pipeline constants and types for the hazard unit.
//   TUSE_NONE       : tuse value meaning "operand not read"
//   REG_ZERO        : hard-wired zero register, never a real producer
//   MULT/DIV_*_DEF  : default mult/div unit busy durations in cycles
//   TUSE_W, CNT_W   : tuse/tnew field width, busy counter width
package pipe_pkg;

   localparam int TUSE_W          = 2;
   localparam int CNT_W           = 4;
   localparam int MULT_CYCLES_DEF = 5;
   localparam int DIV_CYCLES_DEF  = 10;

   typedef logic [TUSE_W-1:0] tuse_t;
   typedef logic [4:0]        reg_t;

   localparam tuse_t TUSE_NONE = 2'd3;
   localparam reg_t  REG_ZERO  = 5'd0;

   // Per-cause hazard flags; the stall is the OR of all fields.
   typedef struct packed {
      logic rs;
      logic rt;
      logic md;
   } hazard_t;

   // A source operand must wait if a younger-than-RF producer in E or M
   // will not have its result ready by the time the operand is consumed.
   // A match on register 0 is impossible because src is checked first.
   function automatic logic src_hazard(input reg_t  src,
                                       input tuse_t tuse,
                                       input reg_t  wa_e,
                                       input tuse_t tnew_e,
                                       input reg_t  wa_m,
                                       input tuse_t tnew_m);
      return (src != REG_ZERO) && (tuse != TUSE_NONE) &&
             (((src == wa_e) && (tnew_e > tuse)) ||
              ((src == wa_m) && (tnew_m > tuse)));
   endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if -- bundle between the pipeline (master) and hazard_ctrl (slave).
//   D-stage operands : rs_D, rt_D, tuse_rs_D, tuse_rt_D, md_D
//   E/M producers    : wa_E, tnew_E, wa_M, tnew_M
//   mult/div issue   : md_start_E, md_is_div_E
//   stall outputs    : stall_F, stall_D, flush_E
//   status           : md_busy, md_count (debug view of busy counter),
//                      stall_cnt, proto_err
//   stall_cnt preload: stall_cnt_load_en / stall_cnt_load_val (debug hook)
// Handshake: there is no valid/ready pair. md_start_E is a single-cycle
// pulse meaning "a mult/div is in E this cycle"; md_is_div_E is only
// meaningful in that cycle. The unit accepts a start only while idle
// (md_busy = 0); a start while busy is ignored and flagged in proto_err.
interface hazard_ctrl_if;
   import pipe_pkg::*;

   reg_t        rs_D;
   reg_t        rt_D;
   tuse_t       tuse_rs_D;
   tuse_t       tuse_rt_D;
   logic        md_D;
   reg_t        wa_E;
   reg_t        wa_M;
   tuse_t       tnew_E;
   tuse_t       tnew_M;
   logic        md_start_E;
   logic        md_is_div_E;
   logic        stall_cnt_load_en;
   logic [31:0] stall_cnt_load_val;

   logic             stall_F;
   logic             stall_D;
   logic             flush_E;
   logic             md_busy;
   logic [CNT_W-1:0] md_count;
   logic [31:0]      stall_cnt;
   logic             proto_err;

   modport master (
      output rs_D, rt_D, tuse_rs_D, tuse_rt_D, md_D,
      output wa_E, wa_M, tnew_E, tnew_M, md_start_E, md_is_div_E,
      output stall_cnt_load_en, stall_cnt_load_val,
      input  stall_F, stall_D, flush_E, md_busy, md_count, stall_cnt, proto_err
   );

   modport slave (
      input  rs_D, rt_D, tuse_rs_D, tuse_rt_D, md_D,
      input  wa_E, wa_M, tnew_E, tnew_M, md_start_E, md_is_div_E,
      input  stall_cnt_load_en, stall_cnt_load_val,
      output stall_F, stall_D, flush_E, md_busy, md_count, stall_cnt, proto_err
   );

endinterface

// File: rtl/md_busy_counter.sv
// md_busy_counter -- tracks how long the mult/div unit stays busy.
//   clk, reset   : clock, synchronous active-high reset
//   md_start_i   : mult/div in E this cycle (pulse)
//   md_is_div_i  : qualifies md_start_i, 1 = div/divu
//   md_busy_o    : unit computing (count != 0)
//   count_o      : current down-count value
//   proto_err_o  : sticky, a start arrived while busy
module md_busy_counter
   import pipe_pkg::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             md_start_i,
   input  logic             md_is_div_i,
   output logic             md_busy_o,
   output logic [CNT_W-1:0] count_o,
   output logic             proto_err_o
);

   if (MULT_CYCLES < 1 || MULT_CYCLES > 15) begin : g_bad_mult
      $error("MULT_CYCLES must be in 1..15");
   end
   if (DIV_CYCLES < 1 || DIV_CYCLES > 15) begin : g_bad_div
      $error("DIV_CYCLES must be in 1..15");
   end

   localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
   localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

   logic [CNT_W-1:0] count_q, count_d;
   logic             proto_err_q, proto_err_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q     <= '0;
         proto_err_q <= 1'b0;
      end else begin
         count_q     <= count_d;
         proto_err_q <= proto_err_d;
      end
   end

   // A start while counting never disturbs the count; it only raises the flag.
   always_comb begin
      count_d     = count_q;
      proto_err_d = proto_err_q;
      if (count_q != '0) begin
         count_d = count_q - 1'b1;
         if (md_start_i) proto_err_d = 1'b1;
      end else if (md_start_i) begin
         count_d = md_is_div_i ? DIV_LOAD : MULT_LOAD;
      end
   end

   assign md_busy_o   = (count_q != '0);
   assign count_o     = count_q;
   assign proto_err_o = proto_err_q;

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- decode-stage stall/flush generation.
//   clk, reset : clock, synchronous active-high reset
//   hz_if      : hazard_ctrl_if.slave (operands, producers, mult/div issue,
//                stall_F/stall_D/flush_E, md_busy, stall_cnt, proto_err)
// Stall outputs are purely combinational from this cycle's inputs plus the
// registered busy state, so the pipeline sees them with zero latency.
module hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
   input logic          clk,
   input logic          reset,
   hazard_ctrl_if.slave hz_if
);

   hazard_t     haz;
   logic        stall;
   logic        md_busy_w;
   logic        md_busy_eff;
   logic [31:0] stall_cnt_q, stall_cnt_d;

   md_busy_counter #(
      .MULT_CYCLES (MULT_CYCLES),
      .DIV_CYCLES  (DIV_CYCLES)
   ) u_md_busy (
      .clk         (clk),
      .reset       (reset),
      .md_start_i  (hz_if.md_start_E),
      .md_is_div_i (hz_if.md_is_div_E),
      .md_busy_o   (md_busy_w),
      .count_o     (hz_if.md_count),
      .proto_err_o (hz_if.proto_err)
   );

   // While reset is held the pending count is already being discarded,
   // so it must not hold the pipeline.
   assign md_busy_eff = md_busy_w & ~reset;

   always_comb begin
      haz.rs = src_hazard(hz_if.rs_D, hz_if.tuse_rs_D, hz_if.wa_E, hz_if.tnew_E,
                          hz_if.wa_M, hz_if.tnew_M);
      haz.rt = src_hazard(hz_if.rt_D, hz_if.tuse_rt_D, hz_if.wa_E, hz_if.tnew_E,
                          hz_if.wa_M, hz_if.tnew_M);
      haz.md = hz_if.md_D & (hz_if.md_start_E | md_busy_eff);
      stall  = |haz;
   end

   // The debug preload takes priority so a saturation point can be reached
   // without billions of cycles.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (hz_if.stall_cnt_load_en) begin
         stall_cnt_d = hz_if.stall_cnt_load_val;
      end else if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) stall_cnt_q <= '0;
      else       stall_cnt_q <= stall_cnt_d;
   end

   assign hz_if.stall_F   = stall;
   assign hz_if.stall_D   = stall;
   assign hz_if.flush_E   = stall;
   assign hz_if.md_busy   = md_busy_w;
   assign hz_if.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic reset;
  bit   chk_en = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  hazard_ctrl_if hif ();

  hazard_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .hz_if (hif)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Busy is modelled as a window of cycle numbers after the accepted start,
  // not as a down-counter.
  int    m_cyc   = 0;
  int    m_start = -1;
  int    m_len   = 0;
  bit    m_proto = 1'b0;
  longint m_stalls = 0;

  function automatic bit m_busy(input int cyc);
    return (m_start >= 0) && (cyc > m_start) && (cyc <= m_start + m_len);
  endfunction

  function automatic int m_count(input int cyc);
    return m_busy(cyc) ? (m_start + m_len + 1 - cyc) : 0;
  endfunction

  function automatic bit src_rule(input int src, input int tuse, input int wae,
                                  input int tne, input int wam, input int tnm);
    if (src == 0 || tuse == 3) return 1'b0;
    if (src == wae && tne > tuse) return 1'b1;
    if (src == wam && tnm > tuse) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_stall(input int cyc);
    bit rs_h, rt_h, md_h;
    rs_h = src_rule(int'(hif.rs_D), int'(hif.tuse_rs_D), int'(hif.wa_E),
                    int'(hif.tnew_E), int'(hif.wa_M), int'(hif.tnew_M));
    rt_h = src_rule(int'(hif.rt_D), int'(hif.tuse_rt_D), int'(hif.wa_E),
                    int'(hif.tnew_E), int'(hif.wa_M), int'(hif.tnew_M));
    md_h = hif.md_D && (hif.md_start_E || (!reset && m_busy(cyc)));
    return rs_h || rt_h || md_h;
  endfunction

  always @(posedge clk) begin
    int  cur;
    bit  st;
    cur = m_cyc;
    st  = m_stall(cur);
    if (reset) begin
      m_start  = -1;
      m_proto  = 1'b0;
      m_stalls = 0;
    end else begin
      if (hif.md_start_E) begin
        if (m_busy(cur)) m_proto = 1'b1;
        else begin
          m_start = cur;
          m_len   = hif.md_is_div_E ? 10 : 5;
        end
      end
      if (hif.stall_cnt_load_en) m_stalls = longint'(hif.stall_cnt_load_val);
      else if (st && m_stalls < 64'hFFFF_FFFF) m_stalls = m_stalls + 1;
    end
    m_cyc = cur + 1;
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    bit es;
    if (chk_en) begin
      es = m_stall(m_cyc);
      chk("stall_F",   32'(hif.stall_F),   32'(es));
      chk("stall_D",   32'(hif.stall_D),   32'(es));
      chk("flush_E",   32'(hif.flush_E),   32'(es));
      chk("md_busy",   32'(hif.md_busy),   32'(m_busy(m_cyc)));
      chk("md_count",  32'(hif.md_count),  32'(m_count(m_cyc)));
      chk("proto_err", 32'(hif.proto_err), 32'(m_proto));
      chk("stall_cnt", hif.stall_cnt,      m_stalls[31:0]);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle();
    hif.rs_D = '0; hif.rt_D = '0; hif.tuse_rs_D = '0; hif.tuse_rt_D = '0;
    hif.md_D = 1'b0; hif.wa_E = '0; hif.wa_M = '0; hif.tnew_E = '0; hif.tnew_M = '0;
    hif.md_start_E = 1'b0; hif.md_is_div_E = 1'b0;
    hif.stall_cnt_load_en = 1'b0; hif.stall_cnt_load_val = '0;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int rs; int tuse_rs; int rt; int tuse_rt;
    int wa_e; int tnew_e; int wa_m; int tnew_m; int exp;
  } vec_t;

  vec_t vecs[10];

  task automatic apply_vec(input vec_t v);
    hif.rs_D = 5'(v.rs); hif.tuse_rs_D = 2'(v.tuse_rs);
    hif.rt_D = 5'(v.rt); hif.tuse_rt_D = 2'(v.tuse_rt);
    hif.wa_E = 5'(v.wa_e); hif.tnew_E = 2'(v.tnew_e);
    hif.wa_M = 5'(v.wa_m); hif.tnew_M = 2'(v.tnew_m);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n_stall, n_busy;
    vecs = '{
      '{ 8, 1,  0, 0,  8, 2,  0, 0, 1},   // load-use in E
      '{ 8, 1,  0, 0,  0, 0,  8, 1, 0},   // same producer now in M, ready
      '{ 0, 0,  0, 0,  0, 2,  0, 0, 0},   // $0 never stalls
      '{ 0, 0,  5, 0,  0, 0,  5, 1, 1},   // rt waits on M
      '{ 0, 0,  5, 3,  5, 2,  0, 0, 0},   // rt unused
      '{ 3, 0,  0, 0,  4, 2,  0, 0, 0},   // different register
      '{ 7, 0,  0, 0,  7, 0,  0, 0, 0},   // result already forwardable
      '{ 9, 2,  0, 0,  9, 3,  0, 0, 1},   // tnew 3 > tuse 2
      '{31, 1, 31, 2,  0, 0, 31, 2, 1},   // rs stalls, rt would not
      '{ 0, 0,  0, 0,  0, 0,  0, 3, 0}    // $0 via M
    };

    reset = 1'b1;
    idle();
    next();
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_stall_cnt", hif.stall_cnt, 32'd0);
    chk("rst_md_busy",   32'(hif.md_busy), 32'd0);
    chk("rst_proto_err", 32'(hif.proto_err), 32'd0);
    next();
    reset = 1'b0;

    // Operand hazards
    for (int i = 0; i < 10; i++) begin
      apply_vec(vecs[i]);
      @(negedge clk);
      chk($sformatf("vec%0d_stall", i), 32'(hif.stall_D), 32'(vecs[i].exp));
      if (i == 3) chk("zero_guard_cnt", hif.stall_cnt, 32'd1);
      next();
    end
    chk("vec_stall_cnt", hif.stall_cnt, 32'd4);
    idle();
    next();

    // Mult busy with md_D held
    hif.md_start_E = 1'b1; hif.md_is_div_E = 1'b0; hif.md_D = 1'b1;
    n_stall = 0; n_busy = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      n_stall += int'(hif.stall_F);
      n_busy  += int'(hif.md_busy);
      next();
      hif.md_start_E = 1'b0;
    end
    chk("mult_stall_cycles", 32'(n_stall), 32'd6);
    chk("mult_busy_cycles",  32'(n_busy),  32'd5);
    chk("mult_stall_cnt",    hif.stall_cnt, 32'd10);
    idle();
    next();

    // Protocol error: second start while count = 3
    hif.md_start_E = 1'b1;
    next();
    hif.md_start_E = 1'b0;
    @(negedge clk); chk("pe_cnt5", 32'(hif.md_count), 32'd5);
    next();
    next();
    hif.md_start_E = 1'b1;
    @(negedge clk); chk("pe_cnt3", 32'(hif.md_count), 32'd3);
    chk("pe_before", 32'(hif.proto_err), 32'd0);
    next();
    hif.md_start_E = 1'b0;
    @(negedge clk); chk("pe_cnt2", 32'(hif.md_count), 32'd2);
    chk("pe_set", 32'(hif.proto_err), 32'd1);
    next();
    @(negedge clk); chk("pe_cnt1", 32'(hif.md_count), 32'd1);
    next();
    @(negedge clk); chk("pe_cnt0", 32'(hif.md_count), 32'd0);
    next(); next();
    @(negedge clk); chk("pe_sticky", 32'(hif.proto_err), 32'd1);
    reset = 1'b1;
    next();
    reset = 1'b0;
    @(negedge clk); chk("pe_cleared", 32'(hif.proto_err), 32'd0);

    // Div busy aborted by reset
    hif.md_D = 1'b1; hif.md_start_E = 1'b1; hif.md_is_div_E = 1'b1;
    next();
    hif.md_start_E = 1'b0;
    @(negedge clk); chk("div_cnt10", 32'(hif.md_count), 32'd10);
    next(); next(); next();
    reset = 1'b1;
    @(negedge clk); chk("div_rst_stall", 32'(hif.stall_F), 32'd0);
    next();
    reset = 1'b0;
    @(negedge clk);
    chk("div_after_busy",  32'(hif.md_busy), 32'd0);
    chk("div_after_stall", 32'(hif.stall_F), 32'd0);
    chk("div_after_cnt",   hif.stall_cnt,    32'd0);
    idle();
    next();

    // Saturation via preload
    hif.stall_cnt_load_en = 1'b1; hif.stall_cnt_load_val = 32'hFFFF_FFFD;
    next();
    hif.stall_cnt_load_en = 1'b0;
    apply_vec(vecs[0]);
    @(negedge clk); chk("sat_preload", hif.stall_cnt, 32'hFFFF_FFFD);
    repeat (5) next();
    @(negedge clk); chk("sat_hold", hif.stall_cnt, 32'hFFFF_FFFF);
    idle();
    next();

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
